rst_sequencer: RTL and testbench

- Sits directly downstream of the top-level reset synchronizer. It consumes the synchronized reset (inverted to active-high at top level) and the PLL lock indication.
- Releases the per-subsystem resets in a fixed order: SDRAM/memory controller, then PPU, then CPU. Each release is gated by lock stability, the memory init handshake, and hold counters.
- Also services a console soft-reset request. A soft reset re-resets PPU and CPU only; memory contents are preserved.

---
 rtl/rst_sequencer_pkg.sv | 27 ++
 rtl/rst_sequencer_if.sv | 36 +++
 rtl/rst_seq_cnt.sv | 25 ++
 rtl/rst_sequencer.sv | 148 ++++++++++++++
 tb/tb_rst_sequencer.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/rst_sequencer_pkg.sv
// Shared state encodings and default cycle constants for the reset sequencer.
// Imported by the RTL and by the bench so both agree on timing.
package rst_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_MEM_INIT  = 3'd1,
        ST_PPU_HOLD  = 3'd2,
        ST_RUN       = 3'd3,
        ST_SOFT      = 3'd4
    } state_t;

    localparam int LOCK_STABLE_CYC_DEF = 1024;
    localparam int HOLD_CYC_DEF        = 16;
    localparam int MEM_TIMEOUT_CYC_DEF = 65535;
    localparam int CNT_W_DEF           = 16;

    // Terminal count (cyc-1), clamped to what a w-bit counter can reach
    function automatic longint unsigned sat_term(input int cyc, input int w);
        longint unsigned mx;
        longint unsigned t;
        mx = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        t  = (cyc < 1) ? 64'd0 : (64'(cyc) - 64'd1);
        return (t > mx) ? mx : t;
    endfunction

endpackage

// File: rtl/rst_sequencer_if.sv
// Lock/init/soft-reset inputs and reset outputs of the sequencer.
// master = sequencer side, slave = system side.
interface rst_sequencer_if;

    logic i_pll_locked;
    logic i_mem_init_done;
    logic i_soft_rst_req;
    logic o_mem_rst;
    logic o_ppu_rst;
    logic o_cpu_rst;
    logic o_ready;
    logic o_mem_timeout;

    modport master (
        input  i_pll_locked,
        input  i_mem_init_done,
        input  i_soft_rst_req,
        output o_mem_rst,
        output o_ppu_rst,
        output o_cpu_rst,
        output o_ready,
        output o_mem_timeout
    );

    modport slave (
        output i_pll_locked,
        output i_mem_init_done,
        output i_soft_rst_req,
        input  o_mem_rst,
        input  o_ppu_rst,
        input  o_cpu_rst,
        input  o_ready,
        input  o_mem_timeout
    );

endinterface

// File: rtl/rst_seq_cnt.sv
// Saturating up-counter with synchronous clear and terminal-count compare.
module rst_seq_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] term,
    output logic             tc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == term);

endmodule

// File: rtl/rst_sequencer.sv
// Ordered release of memory, PPU and CPU resets after PLL lock,
// with memory-init timeout retry and console soft reset.
module rst_sequencer
    import rst_sequencer_pkg::*;
#(
    parameter int LOCK_STABLE_CYC = LOCK_STABLE_CYC_DEF,
    parameter int HOLD_CYC        = HOLD_CYC_DEF,
    parameter int MEM_TIMEOUT_CYC = MEM_TIMEOUT_CYC_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic            i_clk,
    input  logic            i_rst,
    rst_sequencer_if.master bus
);

    if (LOCK_STABLE_CYC < 1 || HOLD_CYC < 1 ||
        MEM_TIMEOUT_CYC < 1 || CNT_W < 1) begin : g_bad_param
        $error("rst_sequencer: parameters must be >= 1");
    end

    localparam logic [CNT_W-1:0] LOCK_TERM =
        CNT_W'(sat_term(LOCK_STABLE_CYC, CNT_W));
    localparam logic [CNT_W-1:0] HOLD_TERM =
        CNT_W'(sat_term(HOLD_CYC, CNT_W));
    localparam logic [CNT_W-1:0] TMO_TERM =
        CNT_W'(sat_term(MEM_TIMEOUT_CYC, CNT_W));

    state_t           state;
    state_t           nxt;
    logic             clr;
    logic             inc;
    logic             tc;
    logic             set_tmo;
    logic [CNT_W-1:0] term;
    logic             mem_n;
    logic             ppu_n;
    logic             cpu_n;
    logic             ready_n;

    rst_seq_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk  (i_clk),
        .rst  (i_rst),
        .clr  (clr),
        .inc  (inc),
        .term (term),
        .tc   (tc)
    );

    always_comb begin
        nxt     = state;
        clr     = 1'b0;
        inc     = 1'b0;
        set_tmo = 1'b0;
        term    = HOLD_TERM;
        if (state != ST_WAIT_LOCK && !bus.i_pll_locked) begin
            nxt = ST_WAIT_LOCK;
            clr = 1'b1;
        end else begin
            unique case (state)
                ST_WAIT_LOCK: begin
                    term = LOCK_TERM;
                    if (!bus.i_pll_locked) begin
                        clr = 1'b1;
                    end else if (tc) begin
                        nxt = ST_MEM_INIT;
                        clr = 1'b1;
                    end else begin
                        inc = 1'b1;
                    end
                end
                ST_MEM_INIT: begin
                    term = TMO_TERM;
                    // Done wins over a coincident timeout
                    if (bus.i_mem_init_done) begin
                        nxt = ST_PPU_HOLD;
                        clr = 1'b1;
                    end else if (tc) begin
                        nxt     = ST_WAIT_LOCK;
                        clr     = 1'b1;
                        set_tmo = 1'b1;
                    end else begin
                        inc = 1'b1;
                    end
                end
                ST_PPU_HOLD, ST_SOFT: begin
                    if (tc) begin
                        nxt = (state == ST_SOFT) ? ST_PPU_HOLD : ST_RUN;
                        clr = 1'b1;
                    end else begin
                        inc = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus.i_soft_rst_req) begin
                        nxt = ST_SOFT;
                        clr = 1'b1;
                    end
                end
                default: begin
                    nxt = ST_WAIT_LOCK;
                    clr = 1'b1;
                end
            endcase
        end
    end

    // Outputs decode the next state so they register on the entry edge
    always_comb begin
        mem_n   = 1'b1;
        ppu_n   = 1'b1;
        cpu_n   = 1'b1;
        ready_n = 1'b0;
        unique case (nxt)
            ST_MEM_INIT: mem_n = 1'b0;
            ST_PPU_HOLD: begin
                mem_n = 1'b0;
                ppu_n = 1'b0;
            end
            ST_RUN: begin
                mem_n   = 1'b0;
                ppu_n   = 1'b0;
                cpu_n   = 1'b0;
                ready_n = 1'b1;
            end
            ST_SOFT: mem_n = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state             <= ST_WAIT_LOCK;
            bus.o_mem_rst     <= 1'b1;
            bus.o_ppu_rst     <= 1'b1;
            bus.o_cpu_rst     <= 1'b1;
            bus.o_ready       <= 1'b0;
            bus.o_mem_timeout <= 1'b0;
        end else begin
            state             <= nxt;
            bus.o_mem_rst     <= mem_n;
            bus.o_ppu_rst     <= ppu_n;
            bus.o_cpu_rst     <= cpu_n;
            bus.o_ready       <= ready_n;
            bus.o_mem_timeout <= bus.o_mem_timeout | set_tmo;
        end
    end

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer: vector table plus hand sequences,
// with a per-cycle reset-order invariant check.
module tb_rst_sequencer;
    import rst_sequencer_pkg::*;

    localparam int LK = 8;
    localparam int HD = 4;
    localparam int TO = 32;

    typedef struct {
        logic       r;
        logic       lk;
        logic       dn;
        logic       sr;
        logic [4:0] exp;
        string      nm;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_pass = 0;
    int   n_tot  = 0;
    bit   inv_en = 1'b0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    rst_sequencer_if bus ();

    rst_sequencer #(
        .LOCK_STABLE_CYC (LK),
        .HOLD_CYC        (HD),
        .MEM_TIMEOUT_CYC (TO),
        .CNT_W           (16)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // exp bits: {mem_rst, ppu_rst, cpu_rst, ready, mem_timeout}
    function automatic void push(int n, logic r, logic lk, logic dn,
                                 logic sr, logic [4:0] e, string nm);
        for (int i = 0; i < n; i++) tbl.push_back('{r, lk, dn, sr, e, nm});
    endfunction

    task automatic step(logic r, logic lk, logic dn, logic sr,
                        logic [4:0] e, string nm);
        logic [4:0] got;
        rst                 = r;
        bus.i_pll_locked    = lk;
        bus.i_mem_init_done = dn;
        bus.i_soft_rst_req  = sr;
        @(posedge clk);
        #1;
        got = {bus.o_mem_rst, bus.o_ppu_rst, bus.o_cpu_rst,
               bus.o_ready, bus.o_mem_timeout};
        n_tot++;
        if (got === e) n_pass++;
        else $display("FAIL %s: got %b want %b (mem,ppu,cpu,ready,tmo)",
                      nm, got, e);
    endtask

    task automatic rep(int n, logic r, logic lk, logic dn,
                       logic [4:0] e, string nm);
        for (int i = 0; i < n; i++) step(r, lk, dn, 1'b0, e, nm);
    endtask

    // CPU out of reset implies PPU and memory out of reset
    always @(negedge clk) begin
        if (inv_en) begin
            n_tot++;
            inv_order: assert (bus.o_cpu_rst ||
                               (!bus.o_ppu_rst && !bus.o_mem_rst))
                n_pass++;
            else $display("FAIL reset_order: mem=%b ppu=%b cpu=%b",
                          bus.o_mem_rst, bus.o_ppu_rst, bus.o_cpu_rst);
        end
    end

    initial begin
        rst                 = 1'b1;
        bus.i_pll_locked    = 1'b0;
        bus.i_mem_init_done = 1'b0;
        bus.i_soft_rst_req  = 1'b0;

        push(2, 1, 0, 0, 0, 5'b11100, "reset");
        // Nominal bring-up
        push(7, 0, 1, 0, 0, 5'b11100, "wait_lock");
        push(1, 0, 1, 0, 0, 5'b01100, "mem_release");
        push(5, 0, 1, 0, 0, 5'b01100, "mem_init");
        push(1, 0, 1, 1, 0, 5'b00100, "ppu_release");
        push(3, 0, 1, 1, 0, 5'b00100, "ppu_hold");
        push(1, 0, 1, 1, 0, 5'b00010, "cpu_release");
        push(2, 0, 1, 0, 0, 5'b00010, "run_ignores_done");
        // Soft reset, second pulse inside ST_SOFT ignored
        push(1, 0, 1, 0, 1, 5'b01100, "soft_enter");
        push(1, 0, 1, 0, 0, 5'b01100, "soft");
        push(1, 0, 1, 0, 1, 5'b01100, "soft_repulse");
        push(1, 0, 1, 0, 0, 5'b01100, "soft");
        push(1, 0, 1, 0, 0, 5'b00100, "soft_ppu_release");
        push(3, 0, 1, 0, 0, 5'b00100, "soft_ppu_hold");
        push(1, 0, 1, 0, 0, 5'b00010, "soft_cpu_release");
        // Lock loss in RUN, then a one-cycle glitch at count 5
        push(1, 0, 0, 0, 0, 5'b11100, "lock_loss_run");
        push(5, 0, 1, 0, 0, 5'b11100, "relock");
        push(1, 0, 0, 0, 0, 5'b11100, "lock_glitch");
        push(7, 0, 1, 0, 0, 5'b11100, "relock_after_glitch");
        push(1, 0, 1, 0, 0, 5'b01100, "glitch_mem_release");
        push(1, 0, 0, 1, 0, 5'b11100, "lock_loss_beats_done");

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].lk, tbl[i].dn, tbl[i].sr,
                 tbl[i].exp, tbl[i].nm);
            inv_en = 1'b1;
        end

        // Init timeout then retry; flag stays sticky
        rep(7, 0, 1, 0, 5'b11100, "to_wait");
        rep(1, 0, 1, 0, 5'b01100, "to_mem_release");
        rep(TO - 1, 0, 1, 0, 5'b01100, "to_mem_init");
        rep(1, 0, 1, 0, 5'b11101, "timeout");
        rep(7, 0, 1, 0, 5'b11101, "retry_wait");
        rep(1, 0, 1, 0, 5'b01101, "retry_mem_release");
        rep(1, 0, 1, 1, 5'b00101, "retry_ppu_release");
        rep(3, 0, 1, 1, 5'b00101, "retry_ppu_hold");
        rep(1, 0, 1, 1, 5'b00011, "retry_run");

        // Reach ST_PPU_HOLD via soft reset, then i_rst mid-sequence
        step(0, 1, 1, 1, 5'b01101, "soft2_enter");
        rep(3, 0, 1, 1, 5'b01101, "soft2");
        rep(1, 0, 1, 1, 5'b00101, "soft2_ppu_release");
        rep(1, 1, 1, 1, 5'b11100, "mid_rst");
        rep(1, 1, 1, 0, 5'b11100, "rst_hold");

        // init_done on the exact timeout cycle counts as done
        rep(7, 0, 1, 0, 5'b11100, "sim_wait");
        rep(1, 0, 1, 0, 5'b01100, "sim_mem_release");
        rep(TO - 1, 0, 1, 0, 5'b01100, "sim_mem_init");
        rep(1, 0, 1, 1, 5'b00100, "done_on_timeout");
        rep(3, 0, 1, 1, 5'b00100, "sim_ppu_hold");
        rep(1, 0, 1, 1, 5'b00010, "sim_run");

        @(negedge clk);
        inv_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
